// File: rtl/dcache_store_buffer.sv
// Committed-store write buffer between the D-cache and the memory/L2 store port.
// Optional store coalescing into the youngest entry: define DCACHE_SB_COALESCE_EN.
module dcache_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        dc2sbStAddr_i,
    input  logic [DATA_W-1:0]        dc2sbStData_i,
    input  logic [DATA_W/8-1:0]      dc2sbStByteEn_i,
    input  logic                     dc2sbStValid_i,
    output logic                     sbFull_o,
    output logic                     sbEmpty_o,
    output logic [$clog2(DEPTH):0]   sbCount_o,
    output logic [ADDR_W-1:0]        sb2memStAddr_o,
    output logic [DATA_W-1:0]        sb2memStData_o,
    output logic [DATA_W/8-1:0]      sb2memStByteEn_o,
    output logic                     sb2memStValid_o,
    input  logic                     mem2sbStStall_i,
    input  logic                     mem2sbStComplete_i,
    input  logic                     ldEn_i,
    input  logic [ADDR_W-1:0]        ldAddr_i,
    output logic                     ldConflict_o,
    output logic                     overflowErr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic {S_ISSUE, S_WAIT} state_t;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BE_W-1:0]   be_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, last_idx;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             ovf_q, ovf_d;
    logic             full, empty, push, pop, merge, hit;
    logic [PTR_W-1:0] off;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign last_idx = tail_q - PTR_W'(1);

`ifdef DCACHE_SB_COALESCE_EN
    // count>=2 keeps the merge target away from the head, which may be in flight
    assign merge = dc2sbStValid_i && (count_q >= CNT_W'(2)) &&
                   (addr_q[last_idx] == dc2sbStAddr_i);
`else
    assign merge = 1'b0;
`endif

    assign push = dc2sbStValid_i && !full && !merge;
    assign pop  = (state_q == S_WAIT) && mem2sbStComplete_i;

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        state_d = state_q;
        unique case (state_q)
            S_ISSUE: if (!empty && !mem2sbStStall_i) state_d = S_WAIT;
            S_WAIT:  if (mem2sbStComplete_i) state_d = S_ISSUE;
            default: state_d = S_ISSUE;
        endcase
        ovf_d = ovf_q | (dc2sbStValid_i & full & ~merge);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= S_ISSUE;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            if (push) begin
                addr_q[tail_q] <= dc2sbStAddr_i;
                data_q[tail_q] <= dc2sbStData_i;
                be_q[tail_q]   <= dc2sbStByteEn_i;
            end
`ifdef DCACHE_SB_COALESCE_EN
            if (merge) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (dc2sbStByteEn_i[b])
                        data_q[last_idx][8*b +: 8] <= dc2sbStData_i[8*b +: 8];
                end
                be_q[last_idx] <= be_q[last_idx] | dc2sbStByteEn_i;
            end
`endif
        end
    end

    // An entry is live when its distance from the head is below the occupancy
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - head_q;
            if (({1'b0, off} < count_q) && (addr_q[i] == ldAddr_i))
                hit = 1'b1;
        end
    end

    assign ldConflict_o     = ldEn_i & hit;
    assign sbFull_o         = full;
    assign sbEmpty_o        = empty;
    assign sbCount_o        = count_q;
    assign overflowErr_o    = ovf_q;
    assign sb2memStValid_o  = (state_q == S_ISSUE) && !empty;
    assign sb2memStAddr_o   = addr_q[head_q];
    assign sb2memStData_o   = data_q[head_q];
    assign sb2memStByteEn_o = be_q[head_q];

endmodule
